tstate_sequencer: RTL and testbench

- Parametrised T-state timing generator for the multi-cycle CPU control unit.
- Replaces the fixed 2-bit timer counter, its timer decoder and the en_timer flop.
- Adds configurable T-state count, memory wait-state stalls with timeout, a latched halt with resume, and an instruction-complete pulse.
- Drives the control unit decode logic, which consumes time_cycle, T and fetch.

---
 rtl/tstate_sequencer.sv | 150 +++++++++++++++
 tb/tb_tstate_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tstate_sequencer.sv
// T-state timing generator for the multi-cycle CPU control unit.
// Produces the current T-state index, its one-hot decode and an opcode-fetch
// flag, with memory wait-state stalls (optional timeout), an external hold
// level, a latched HLT with resume, and instruction-complete/timeout pulses.
// Optional build macro: TSEQ_INSTR_COUNT_EN adds a 16-bit retired-instruction
// counter output (instr_count_o).
module tstate_sequencer #(
  parameter int unsigned STATE_WIDTH    = 3,
  parameter int unsigned FETCH_STATES   = 2,
  parameter int unsigned WAIT_CNT_WIDTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        hlt_i,
  input  logic                        hlt_instr_i,
  input  logic                        resume_i,
  input  logic                        clr_timer_i,
  input  logic                        wait_req_i,
  input  logic [WAIT_CNT_WIDTH-1:0]   max_wait_i,
  output logic [STATE_WIDTH-1:0]      time_cycle_o,
  output logic [2**STATE_WIDTH-1:0]   t_o,
  output logic                        en_timer_o,
  output logic                        fetch_o,
  output logic                        halted_o,
  output logic                        stalled_o,
  output logic                        timeout_o,
`ifdef TSEQ_INSTR_COUNT_EN
  output logic [15:0]                 instr_count_o,
`endif
  output logic                        instr_done_o
);

  localparam int unsigned NumStates = 2**STATE_WIDTH;

  // StInit covers the single not-yet-enabled cycle after reset; StHalt is the
  // HLT latch.
  typedef enum logic [1:0] {StInit, StRun, StHalt} state_e;

  state_e                    state_q;
  logic [STATE_WIDTH-1:0]    time_cycle_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q;
  logic                      timeout_q;
  logic                      instr_done_q;

  logic                      en_timer;
  logic                      halt_latch;
  logic                      halted;
  logic                      force_adv;
  logic                      stalled;
  logic                      active;
  logic                      last_state;
  logic                      instr_done_d;
  logic                      timeout_d;
  logic [WAIT_CNT_WIDTH-1:0] max_wait_m1;

  // Status decode and next-pulse conditions shared by the state and counter flops.
  always_comb begin
    en_timer     = (state_q != StInit);
    halt_latch   = (state_q == StHalt);
    halted       = halt_latch | hlt_i;
    max_wait_m1  = max_wait_i - {{(WAIT_CNT_WIDTH-1){1'b0}}, 1'b1};
    force_adv    = (max_wait_i != '0) && (wait_cnt_q == max_wait_m1);
    stalled      = en_timer && wait_req_i && !halted && !force_adv;
    last_state   = &time_cycle_q;
    // Running and not held: the only case where hlt_instr/stall/advance apply.
    active       = (state_q == StRun) && !hlt_i;
    instr_done_d = active && (hlt_instr_i || (!stalled && (clr_timer_i || last_state)));
    timeout_d    = active && !hlt_instr_i && wait_req_i && force_adv;
  end

  // One-hot T-state decode and fetch flag, gated off before enable and while latched.
  always_comb begin
    t_o = '0;
    for (int i = 0; i < NumStates; i++) begin
      t_o[i] = en_timer && !halt_latch && (time_cycle_q == STATE_WIDTH'(i));
    end
    fetch_o = en_timer && !halt_latch && (32'(time_cycle_q) < FETCH_STATES);
  end

  // Sequencer FSM: enable, hold, halt latch, stall and T-state advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StInit;
      time_cycle_q <= '0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      timeout_q    <= timeout_d;
      instr_done_q <= instr_done_d;
      unique case (state_q)
        StInit: begin
          state_q <= StRun;
        end
        StHalt: begin
          // hlt_instr in the same cycle as resume keeps the latch set.
          if (!hlt_i && resume_i && !hlt_instr_i) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (hlt_i) begin
            // External hold freezes everything, including the wait counter.
          end else if (hlt_instr_i) begin
            state_q      <= StHalt;
            time_cycle_q <= '0;
            wait_cnt_q   <= '0;
          end else if (stalled) begin
            if (wait_cnt_q != '1) begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end else begin
            wait_cnt_q <= '0;
            if (clr_timer_i || last_state) begin
              time_cycle_q <= '0;
            end else begin
              time_cycle_q <= time_cycle_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StInit;
        end
      endcase
    end
  end

`ifdef TSEQ_INSTR_COUNT_EN
  logic [15:0] instr_count_q;

  // Retired-instruction counter, stepped on the same edge that raises instr_done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_count_q <= '0;
    end else if (instr_done_d) begin
      instr_count_q <= instr_count_q + 16'd1;
    end
  end

  assign instr_count_o = instr_count_q;
`endif

  assign time_cycle_o = time_cycle_q;
  assign en_timer_o   = en_timer;
  assign halted_o     = halted;
  assign stalled_o    = stalled;
  assign timeout_o    = timeout_q;
  assign instr_done_o = instr_done_q;

endmodule

// File: tb/tb_tstate_sequencer.sv
// Directed self-checking bench for tstate_sequencer (default parameters).
module tb_tstate_sequencer;

  logic       clk_i;
  logic       rst_ni;
  logic       hlt_i;
  logic       hlt_instr_i;
  logic       resume_i;
  logic       clr_timer_i;
  logic       wait_req_i;
  logic [3:0] max_wait_i;
  logic [2:0] time_cycle_o;
  logic [7:0] t_o;
  logic       en_timer_o;
  logic       fetch_o;
  logic       halted_o;
  logic       stalled_o;
  logic       timeout_o;
  logic       instr_done_o;
`ifdef TSEQ_INSTR_COUNT_EN
  logic [15:0] instr_count_o;
`endif

  int checks;
  int failures;

  tstate_sequencer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .hlt_i        (hlt_i),
    .hlt_instr_i  (hlt_instr_i),
    .resume_i     (resume_i),
    .clr_timer_i  (clr_timer_i),
    .wait_req_i   (wait_req_i),
    .max_wait_i   (max_wait_i),
    .time_cycle_o (time_cycle_o),
    .t_o          (t_o),
    .en_timer_o   (en_timer_o),
    .fetch_o      (fetch_o),
    .halted_o     (halted_o),
    .stalled_o    (stalled_o),
    .timeout_o    (timeout_o),
`ifdef TSEQ_INSTR_COUNT_EN
    .instr_count_o(instr_count_o),
`endif
    .instr_done_o (instr_done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reset, release, and leave the DUT presenting T0 (T=0x01).
  task automatic do_reset();
    hlt_i = 0; hlt_instr_i = 0; resume_i = 0; clr_timer_i = 0; wait_req_i = 0;
    rst_ni = 0;
    step();
    rst_ni = 1;
    step();
  endtask

  task automatic test_reset();
    logic [7:0] exp_t;
    rst_ni = 0; hlt_i = 0; hlt_instr_i = 0; resume_i = 0; clr_timer_i = 0;
    wait_req_i = 0; max_wait_i = 0;
    #1;
    checks++; if (t_o !== 8'h00 || en_timer_o !== 1'b0 || fetch_o !== 1'b0) begin
      failures++; $display("FAIL reset_outputs t=%h en=%b fetch=%b required 00 0 0", t_o, en_timer_o, fetch_o);
    end
    checks++; if (time_cycle_o !== 3'd0 || stalled_o !== 1'b0 || halted_o !== 1'b0 ||
                  timeout_o !== 1'b0 || instr_done_o !== 1'b0) begin
      failures++; $display("FAIL reset_status tc=%0d st=%b h=%b to=%b done=%b required 0 0 0 0 0",
                           time_cycle_o, stalled_o, halted_o, timeout_o, instr_done_o);
    end
    hlt_i = 1; #1;
    checks++; if (halted_o !== 1'b1) begin
      failures++; $display("FAIL reset_halted_follows_hlt got=%b required 1", halted_o);
    end
    hlt_i = 0;
    step();
    rst_ni = 1;
    #1;
    checks++; if (t_o !== 8'h00 || en_timer_o !== 1'b0) begin
      failures++; $display("FAIL release_first_cycle t=%h en=%b required 00 0", t_o, en_timer_o);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      exp_t = 8'h01 << (i % 8);
      checks++; if (t_o !== exp_t || fetch_o !== ((i % 8) < 2) ||
                    instr_done_o !== (i == 8) || en_timer_o !== 1'b1) begin
        failures++; $display("FAIL free_run[%0d] t=%h fetch=%b done=%b en=%b required %h %b %b 1",
                             i, t_o, fetch_o, instr_done_o, en_timer_o, exp_t, (i % 8) < 2, i == 8);
      end
    end
  endtask

  task automatic test_clr_timer();
    do_reset();
    step(); step();
    checks++; if (t_o !== 8'h04) begin
      failures++; $display("FAIL clr_at_t2_pre t=%h required 04", t_o);
    end
    clr_timer_i = 1;
    step();
    clr_timer_i = 0;
    checks++; if (t_o !== 8'h01 || instr_done_o !== 1'b1 || fetch_o !== 1'b1) begin
      failures++; $display("FAIL clr_to_t0 t=%h done=%b fetch=%b required 01 1 1", t_o, instr_done_o, fetch_o);
    end
    step();
    checks++; if (t_o !== 8'h02 || instr_done_o !== 1'b0) begin
      failures++; $display("FAIL clr_after t=%h done=%b required 02 0", t_o, instr_done_o);
    end
  endtask

  task automatic test_wait_unbounded();
    max_wait_i = 0;
    do_reset();
    step();
    wait_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) wait_req_i = 0;
      #1;
      checks++; if (t_o !== 8'h02 || stalled_o !== (i < 3) || timeout_o !== 1'b0) begin
        failures++; $display("FAIL wait_unbounded[%0d] t=%h st=%b to=%b required 02 %b 0",
                             i, t_o, stalled_o, timeout_o, i < 3);
      end
      step();
    end
    checks++; if (t_o !== 8'h04 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL wait_unbounded_exit t=%h to=%b required 04 0", t_o, timeout_o);
    end
  endtask

  task automatic test_wait_timeout();
    max_wait_i = 4;
    do_reset();
    step();
    wait_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (t_o !== 8'h02 || stalled_o !== (i < 3) || timeout_o !== 1'b0) begin
        failures++; $display("FAIL wait_timeout[%0d] t=%h st=%b to=%b required 02 %b 0",
                             i, t_o, stalled_o, timeout_o, i < 3);
      end
      step();
    end
    wait_req_i = 0;
    checks++; if (t_o !== 8'h04 || timeout_o !== 1'b1) begin
      failures++; $display("FAIL timeout_pulse t=%h to=%b required 04 1", t_o, timeout_o);
    end
    step();
    checks++; if (t_o !== 8'h08 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL timeout_single t=%h to=%b required 08 0", t_o, timeout_o);
    end
    // max_wait=1 forces immediately: no stall cycles at all.
    max_wait_i = 1;
    wait_req_i = 1;
    #1;
    checks++; if (stalled_o !== 1'b0) begin
      failures++; $display("FAIL max_wait1_stall st=%b required 0", stalled_o);
    end
    step();
    wait_req_i = 0;
    checks++; if (t_o !== 8'h10 || timeout_o !== 1'b1) begin
      failures++; $display("FAIL max_wait1_adv t=%h to=%b required 10 1", t_o, timeout_o);
    end
    max_wait_i = 0;
  endtask

  task automatic test_halt_resume();
    do_reset();
    // resume while running must be ignored
    resume_i = 1;
    step();
    resume_i = 0;
    checks++; if (t_o !== 8'h02 || halted_o !== 1'b0) begin
      failures++; $display("FAIL resume_ignored t=%h h=%b required 02 0", t_o, halted_o);
    end
    step();
    hlt_instr_i = 1;
    step();
    hlt_instr_i = 0;
    for (int i = 0; i < 5; i++) begin
      // cycle 2: resume and hlt_instr together keep the latch
      if (i == 2) begin resume_i = 1; hlt_instr_i = 1; end
      if (i == 4) resume_i = 1;
      #1;
      checks++; if (t_o !== 8'h00 || halted_o !== 1'b1 || time_cycle_o !== 3'd0 ||
                    instr_done_o !== (i == 0) || fetch_o !== 1'b0) begin
        failures++; $display("FAIL halted[%0d] t=%h h=%b tc=%0d done=%b fetch=%b required 00 1 0 %b 0",
                             i, t_o, halted_o, time_cycle_o, instr_done_o, fetch_o, i == 0);
      end
      step();
      resume_i = 0; hlt_instr_i = 0;
    end
    checks++; if (t_o !== 8'h01 || halted_o !== 1'b0 || instr_done_o !== 1'b0) begin
      failures++; $display("FAIL resumed t=%h h=%b done=%b required 01 0 0", t_o, halted_o, instr_done_o);
    end
  endtask

  task automatic test_hlt_hold();
`ifdef TSEQ_INSTR_COUNT_EN
    logic [15:0] cnt_before;
`endif
    max_wait_i = 4;
    do_reset();
    step(); step(); step();
    wait_req_i = 1;
    #1;
    checks++; if (t_o !== 8'h08 || stalled_o !== 1'b1) begin
      failures++; $display("FAIL hold_pre t=%h st=%b required 08 1", t_o, stalled_o);
    end
    step();
    hlt_i = 1;
`ifdef TSEQ_INSTR_COUNT_EN
    cnt_before = instr_count_o;
`endif
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (time_cycle_o !== 3'd3 || halted_o !== 1'b1 || stalled_o !== 1'b0 ||
                    timeout_o !== 1'b0) begin
        failures++; $display("FAIL hold[%0d] tc=%0d h=%b st=%b to=%b required 3 1 0 0",
                             i, time_cycle_o, halted_o, stalled_o, timeout_o);
      end
      step();
    end
    hlt_i = 0;
`ifdef TSEQ_INSTR_COUNT_EN
    checks++; if (instr_count_o !== cnt_before) begin
      failures++; $display("FAIL hold_count got=%0d required %0d", instr_count_o, cnt_before);
    end
`endif
    // One stall was spent before the hold, so two more remain before the timeout.
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (t_o !== 8'h08 || stalled_o !== (i < 2) || timeout_o !== 1'b0) begin
        failures++; $display("FAIL hold_after[%0d] t=%h st=%b to=%b required 08 %b 0",
                             i, t_o, stalled_o, timeout_o, i < 2);
      end
      step();
    end
    wait_req_i = 0;
    checks++; if (t_o !== 8'h10 || timeout_o !== 1'b1) begin
      failures++; $display("FAIL hold_timeout t=%h to=%b required 10 1", t_o, timeout_o);
    end
    max_wait_i = 0;
  endtask

  task automatic test_reset_mid_stall();
    max_wait_i = 0;
    do_reset();
    step();
    wait_req_i = 1;
    step();
    clr_timer_i = 1;
    #1;
    checks++; if (stalled_o !== 1'b1 || t_o !== 8'h02) begin
      failures++; $display("FAIL stall_beats_clr st=%b t=%h required 1 02", stalled_o, t_o);
    end
    rst_ni = 0;
    #1;
    checks++; if (t_o !== 8'h00 || time_cycle_o !== 3'd0 || stalled_o !== 1'b0 ||
                  en_timer_o !== 1'b0 || instr_done_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid_stall t=%h tc=%0d st=%b en=%b done=%b required 00 0 0 0 0",
                           t_o, time_cycle_o, stalled_o, en_timer_o, instr_done_o);
    end
    step();
    checks++; if (instr_done_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++; $display("FAIL reset_no_pulse done=%b to=%b required 0 0", instr_done_o, timeout_o);
    end
    wait_req_i = 0; clr_timer_i = 0;
    rst_ni = 1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_clr_timer();
    test_wait_unbounded();
    test_wait_timeout();
    test_halt_resume();
    test_hlt_hold();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
